// File: rtl/attn_tile_bank_buffer.sv
// Ring of NUM_BANKS tile banks between the score accumulator (writer) and the attention consumer (reader).
// Optional macro ATTN_BUF_FLUSH_EN adds a synchronous i_flush that clears pointers, read-valid and sticky flags.
module attn_tile_bank_buffer #(
  parameter int DATA_W     = 20,
  parameter int TILE_DEPTH = 4096,
  parameter int NUM_BANKS  = 2,
  localparam int ADDR_W    = $clog2(TILE_DEPTH),
  localparam int PTR_W     = $clog2(NUM_BANKS) + 1
) (
  input  logic              s_clk,
  input  logic              s_rst,
`ifdef ATTN_BUF_FLUSH_EN
  input  logic              i_flush,
`endif
  input  logic [DATA_W-1:0] i_Calc_data,
  input  logic              i_Calc_valid,
  output logic              o_AttnRAM_Ready,
  input  logic              i_AttnRam_rd_en,
  input  logic [ADDR_W-1:0] i_AttnRam_rd_addr,
  output logic [DATA_W-1:0] o_AttnRAM_data,
  output logic              o_AttnRAM_rd_valid,
  input  logic              i_AttnRam_Done,
  output logic              o_AttnRAM_Empty,
  output logic [PTR_W-1:0]  o_tile_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int BANK_W = PTR_W - 1;

  logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic              rd_valid_q, rd_valid_d;
  logic              data_seen_q, data_seen_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              flush_w;
  logic              empty_w, full_w;
  logic              wr_fire, rd_fire, rel_fire, tile_last;
  logic [DATA_W-1:0] bank_rd_word [NUM_BANKS];

`ifdef ATTN_BUF_FLUSH_EN
  assign flush_w = i_flush;
`else
  assign flush_w = 1'b0;
`endif

  // Extra wrap bit on the pointers distinguishes full from empty when bank indices match.
  assign empty_w = (wp_q == rp_q);
  assign full_w  = (wp_q[PTR_W-1] != rp_q[PTR_W-1]) &&
                   (wp_q[BANK_W-1:0] == rp_q[BANK_W-1:0]);

  assign wr_fire   = i_Calc_valid && !full_w && !flush_w;
  assign rd_fire   = i_AttnRam_rd_en && !empty_w && !flush_w;
  assign rel_fire  = i_AttnRam_Done && !empty_w && !flush_w;
  assign tile_last = (wr_addr_q == {ADDR_W{1'b1}});

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    wr_addr_d   = wr_addr_q;
    rd_bank_d   = rd_bank_q;
    rd_valid_d  = 1'b0;
    data_seen_d = data_seen_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush_w) begin
      wp_d        = '0;
      rp_d        = '0;
      wr_addr_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        if (tile_last) wp_d = wp_q + PTR_W'(1);
      end
      if (rel_fire) rp_d = rp_q + PTR_W'(1);
      if (rd_fire) begin
        rd_valid_d  = 1'b1;
        rd_bank_d   = rp_q[BANK_W-1:0];
        data_seen_d = 1'b1;
      end
      if (i_Calc_valid && full_w) overflow_d = 1'b1;
      if ((i_AttnRam_Done || i_AttnRam_rd_en) && empty_w) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      wr_addr_q   <= '0;
      rd_bank_q   <= '0;
      rd_valid_q  <= 1'b0;
      data_seen_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      wr_addr_q   <= wr_addr_d;
      rd_bank_q   <= rd_bank_d;
      rd_valid_q  <= rd_valid_d;
      data_seen_q <= data_seen_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Each bank keeps its own registered read word so the RAM output register maps onto block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [TILE_DEPTH];
      logic [DATA_W-1:0] rd_word_q;

      always_ff @(posedge s_clk) begin
        if (wr_fire && (wp_q[BANK_W-1:0] == BANK_W'(gi)))
          mem[wr_addr_q] <= i_Calc_data;
        if (rd_fire && (rp_q[BANK_W-1:0] == BANK_W'(gi)))
          rd_word_q <= mem[i_AttnRam_rd_addr];
      end

      assign bank_rd_word[gi] = rd_word_q;
    end
  endgenerate

  // Bank select is latched with the request; output reads as zero until the first real read.
  assign o_AttnRAM_data     = data_seen_q ? bank_rd_word[rd_bank_q] : '0;
  assign o_AttnRAM_rd_valid = rd_valid_q;
  assign o_AttnRAM_Ready    = !full_w;
  assign o_AttnRAM_Empty    = empty_w;
  assign o_tile_count       = wp_q - rp_q;
  assign o_overflow         = overflow_q;
  assign o_underflow        = underflow_q;

endmodule

// File: tb/tb_attn_tile_bank_buffer.sv
// Self-checking bench for attn_tile_bank_buffer: write/read scoreboard, full/empty, simultaneous events, reset, flush.
module tb_attn_tile_bank_buffer;

  localparam int DW    = 20;
  localparam int DEPTH = 4096;
  localparam int NB    = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(NB) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
`ifdef ATTN_BUF_FLUSH_EN
  logic          flush = 1'b0;
`endif
  logic [DW-1:0] calc_data = '0;
  logic          calc_valid = 1'b0;
  logic          ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done = 1'b0;
  logic          empty;
  logic [PW-1:0] tile_count;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q [$];

  attn_tile_bank_buffer #(.DATA_W(DW), .TILE_DEPTH(DEPTH), .NUM_BANKS(NB)) dut (
    .s_clk              (clk),
    .s_rst              (rst),
`ifdef ATTN_BUF_FLUSH_EN
    .i_flush            (flush),
`endif
    .i_Calc_data        (calc_data),
    .i_Calc_valid       (calc_valid),
    .o_AttnRAM_Ready    (ready),
    .i_AttnRam_rd_en    (rd_en),
    .i_AttnRam_rd_addr  (rd_addr),
    .o_AttnRAM_data     (rd_data),
    .o_AttnRAM_rd_valid (rd_valid),
    .i_AttnRam_Done     (done),
    .o_AttnRAM_Empty    (empty),
    .o_tile_count       (tile_count),
    .o_overflow         (overflow),
    .o_underflow        (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      calc_data  = DW'(start + i);
      calc_valid = 1'b1;
      tick();
    end
    calc_valid = 1'b0;
  endtask

  // Pop one expected word and compare with what the DUT produced this cycle.
  task automatic collect(input string tag);
    logic [DW-1:0] e;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rd_data, e);
      $display("read %s: data=%0h expected=%0h", tag, rd_data, e);
    end
  endtask

  task automatic read_word(input string tag, input int addr, input int exp_val);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    exp_q.push_back(DW'(exp_val));
    tick();
    rd_en = 1'b0;
    collect(tag);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_ready", ready, 1);
    check("rst_empty", empty, 1);
    check("rst_count", tile_count, 0);
    check("rst_rdvalid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_flags", {overflow, underflow}, 0);

    // First tile: Empty holds until the last word is accepted.
    write_words(DEPTH - 1, 0);
    check("t1_empty_before", empty, 1);
    check("t1_count_before", tile_count, 0);
    write_words(1, DEPTH - 1);
    check("t1_empty_after", empty, 0);
    check("t1_count", tile_count, 1);
    check("t1_ready", ready, 1);

    // Second tile fills the ring; one extra word is dropped.
    write_words(DEPTH, DEPTH);
    check("t2_ready", ready, 0);
    check("t2_count", tile_count, 2);
    check("t2_ovf_before", overflow, 0);
    write_words(1, 'hABCDE);
    check("t2_ovf", overflow, 1);
    check("t2_count_after", tile_count, 2);
    check("t2_unf", underflow, 0);

    read_word("t3_a0", 0, 0);
    read_word("t3_a1", 1, 1);
    read_word("t3_a4095", DEPTH - 1, DEPTH - 1);
    tick();
    check("t3_idle_valid", rd_valid, 0);
    pulse_done();
    check("t3_count", tile_count, 1);
    check("t3_ready", ready, 1);
    read_word("t3_b0", 0, DEPTH);
    read_word("t3_b1", 1, DEPTH + 1);
    read_word("t3_b4095", DEPTH - 1, 2 * DEPTH - 1);

    // Tile completion, Done and a read of the released bank all in one cycle.
    write_words(DEPTH - 1, 2 * DEPTH);
    calc_data  = DW'(3 * DEPTH - 1);
    calc_valid = 1'b1;
    done       = 1'b1;
    rd_en      = 1'b1;
    rd_addr    = AW'(7);
    exp_q.push_back(DW'(DEPTH + 7));
    tick();
    calc_valid = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    collect("t4_same_cycle");
    check("t4_count", tile_count, 1);
    check("t4_empty", empty, 0);
    check("t4_ready", ready, 1);
    read_word("t4_c0", 0, 2 * DEPTH);
    read_word("t4_c4095", DEPTH - 1, 3 * DEPTH - 1);
    pulse_done();
    check("t4_empty_end", empty, 1);
    check("t4_count_end", tile_count, 0);

    // Underflow: Done and rd_en with nothing to read.
    done    = 1'b1;
    rd_en   = 1'b1;
    rd_addr = AW'(3);
    tick();
    done  = 1'b0;
    rd_en = 1'b0;
    check("t5_rdvalid", rd_valid, 0);
    check("t5_unf", underflow, 1);
    check("t5_count", tile_count, 0);
    check("t5_data_hold", rd_data, 3 * DEPTH - 1);

    // Asynchronous reset in the middle of a tile.
    write_words(100, 'h30000);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", ready, 1);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_count", tile_count, 0);
    check("t5_rst_flags", {overflow, underflow}, 0);
    check("t5_rst_rdvalid", rd_valid, 0);
    check("t5_rst_data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();
    write_words(DEPTH, 'h50000);
    check("t5_count_after", tile_count, 1);
    read_word("t5_a0", 0, 'h50000);
    read_word("t5_a100", 100, 'h50000 + 100);
    pulse_done();

`ifdef ATTN_BUF_FLUSH_EN
    write_words(2 * DEPTH + 1, 'h60000);
    check("t6_count_before", tile_count, 2);
    check("t6_ovf_before", overflow, 1);
    flush      = 1'b1;
    calc_valid = 1'b1;
    calc_data  = DW'('hFFFFF);
    tick();
    flush      = 1'b0;
    calc_valid = 1'b0;
    check("t6_count", tile_count, 0);
    check("t6_empty", empty, 1);
    check("t6_flags", {overflow, underflow}, 0);
    write_words(DEPTH, 'h70000);
    check("t6_count_after", tile_count, 1);
    read_word("t6_a0", 0, 'h70000);
    read_word("t6_a1", 1, 'h70001);
`endif

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
